voice_mix_sched: RTL
====================

# voice_mix_sched

Time-multiplexes one shared `mixer` instance across `NUM_VOICES` synthesizer voices, folding all enabled voices into one 18-bit output sample per audio frame. It sits between the voice generators and the DAC/PWM output stage. For each voice it selects the sample, feeds the running accumulator and the voice sample into the mixer, and waits out the mixer pipeline. It then presents the final sample with a one-cycle valid strobe.

## Interface
- `NUM_VOICES`, 8: number of voices scanned per frame (≥1).
- `MIX_LATENCY`, 3: edges from mixer input capture to valid `Z`.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `sample_tick` in 1: one-cycle frame start pulse.
- `voice_en` in NUM_VOICES: per-voice enable mask, captured at frame start.
- `voice_sel` out clog2(NUM_VOICES): index of voice being read.
- `voice_sample` in 18: sample of `voice_sel`, valid combinationally in the same cycle.
- `mix_a`, `mix_b` out 18: registered mixer operands; connect to mixer `A`/`B`.
- `mix_z` in 18: mixer result `Z`.
- `out_sample` out 18: mixed frame sample.
- `out_valid` out 1: one-cycle strobe when `out_sample` updates.
- `busy` out 1: frame in progress.
- `overrun` out 1: one-cycle pulse, `sample_tick` arrived while busy.

## Operation
- States: IDLE, SCAN, WAIT, DONE.
- IDLE, on `sample_tick`:
  - Capture `voice_en` into `en_q`.
  - Set `idx=0`, `have_acc=0`.
  - Go to SCAN.
- SCAN: `voice_sel=idx`.
  - Voice disabled: no action.
  - Voice enabled, `!have_acc`: load `acc<=voice_sample`, set `have_acc<=1`; no mixer pass.
  - Voice enabled, `have_acc`: load `mix_a<=acc`, `mix_b<=voice_sample`, `wcnt<=MIX_LATENCY`; go to WAIT.
  - Otherwise: if `idx==NUM_VOICES-1` go to DONE, else `idx++`.
- WAIT:
  - Decrement `wcnt` each cycle; `mix_a`/`mix_b` held stable.
  - When `wcnt==0`: capture `acc<=mix_z`.
  - Then go to DONE if `idx` was the last voice; else `idx++` and return to SCAN.
- DONE:
  - `out_sample<=have_acc ? acc : SILENCE` (`SILENCE`=18'h20000).
  - `out_valid<=1` for one cycle.
  - Go to IDLE.
- Arithmetic: no widening. The accumulator is always a raw 18-bit mixer output or voice sample.
- `voice_en` changes mid-frame are ignored; only `en_q` is used.
- `sample_tick` while state≠IDLE: ignored, `overrun` pulses next cycle, frame continues.
- `sample_tick` in the same cycle DONE→IDLE completes: the state is DONE, so this counts as an overrun.
- Reset mid-frame: abort immediately, no `out_valid` for that frame.

## Timing
- Reset values:
  - state IDLE, `idx` 0, `acc` 0.
  - `mix_a`, `mix_b` 18'h20000.
  - `out_sample` 18'h20000.
  - `out_valid`, `busy`, `overrun` 0.
  - `voice_sel` 0.
- Frame latency, with the tick sampled at edge t0 and P = popcount(`en_q`), M = max(P−1, 0):
  - `out_valid` rises at edge t0 + NUM_VOICES + M·(MIX_LATENCY+1) + 1.
  - Example: NUM_VOICES=8, all enabled → t0+37.
- `busy` = (state≠IDLE). It rises at t0 and falls on the same edge `out_valid` rises.
- Mixer operands are stable from the issue edge until after `mix_z` is captured.

## Configuration
- `VOICE_MIX_SCHED_OVERRUN_CNT_EN` defined:
  - Adds output `overrun_cnt` [15:0].
  - Increments on every `overrun` pulse and saturates at 16'hFFFF.
  - Cleared only by `rst`.
- Not defined: port and counter absent; `overrun` pulse unchanged.

## Structure
- Shared package `mix_pkg`:
  - `SAMPLE_W`=18.
  - `SILENCE`=18'h20000.
  - Scheduler state enum.
- The mixer is instantiated outside this block (in the top-level audio path); this block only drives and reads its ports.
- No sub-module: the state machine, index counter and wait counter all live in one module.

## Test plan
The bench uses a stub mixer, Z = (A+B) mod 2^18, with 3-cycle latency.
- Only voice 0 enabled, `voice_sample`=18'h00123, tick → `out_sample`=18'h00123 with `out_valid` at t0+9, and no `mix_a`/`mix_b` change.
- Voices 1, 2, 4 enabled with samples 18'h00010, 18'h00020, 18'h00040 → `out_sample`=18'h00070 at t0+8+2·4+1=t0+17.
- `voice_en`=0, tick → `out_sample`=18'h20000 at t0+9.
- All 8 enabled with samples i+1; second tick at t0+10 → `overrun` pulse at t0+11, `out_sample`=18'h00024 at t0+37, and no second `out_valid`.
- `rst` asserted at t0+15 of a full frame → all outputs at reset values next cycle, no `out_valid`; a fresh tick completes normally.
- With `VOICE_MIX_SCHED_OVERRUN_CNT_EN` defined: 3 overrun ticks → `overrun_cnt`=3; `rst` → 0.

Source files
------------

// File: rtl/mix_pkg.sv
// Shared definitions for the voice mixing scheduler: sample width, the
// silence code used when no voice contributes, and the scheduler states.
package mix_pkg;

   localparam int          SAMPLE_W = 18;
   localparam logic [17:0] SILENCE  = 18'h20000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } sched_state_e;

endpackage

// File: rtl/voice_mix_sched.sv
// voice_mix_sched: scans NUM_VOICES voices once per frame and folds every
// enabled voice into a single sample through one shared, externally
// instantiated mixer. The first enabled voice seeds the accumulator directly.
// Each further enabled voice is issued to the mixer, and the scheduler waits
// MIX_LATENCY+1 cycles before taking the result back.
// Optional build macro VOICE_MIX_SCHED_OVERRUN_CNT_EN adds a saturating
// 16-bit overrun counter output (overrun_cnt).
module voice_mix_sched
   import mix_pkg::*;
#(
   parameter int NUM_VOICES  = 8,
   parameter int MIX_LATENCY = 3,
   localparam int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
   localparam int WCNT_W     = (MIX_LATENCY > 0) ? $clog2(MIX_LATENCY + 1) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sample_tick,
   input  logic [NUM_VOICES-1:0] voice_en,
   output logic [IDX_W-1:0]      voice_sel,
   input  logic [SAMPLE_W-1:0]   voice_sample,
   output logic [SAMPLE_W-1:0]   mix_a,
   output logic [SAMPLE_W-1:0]   mix_b,
   input  logic [SAMPLE_W-1:0]   mix_z,
   output logic [SAMPLE_W-1:0]   out_sample,
   output logic                  out_valid,
   output logic                  busy,
`ifdef VOICE_MIX_SCHED_OVERRUN_CNT_EN
   output logic [15:0]           overrun_cnt,
`endif
   output logic                  overrun
);

   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_VOICES - 1);
   localparam logic [WCNT_W-1:0] WCNT_INI = WCNT_W'(MIX_LATENCY);

   sched_state_e              state_q, state_d;
   logic [NUM_VOICES-1:0]     en_q, en_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      have_acc_q, have_acc_d;
   logic [SAMPLE_W-1:0]       acc_q, acc_d;
   logic [WCNT_W-1:0]         wcnt_q, wcnt_d;
   logic [SAMPLE_W-1:0]       mix_a_q, mix_a_d;
   logic [SAMPLE_W-1:0]       mix_b_q, mix_b_d;
   logic [SAMPLE_W-1:0]       out_sample_q, out_sample_d;
   logic                      out_valid_q, out_valid_d;
   logic                      overrun_q, overrun_d;
   logic                      last_voice;

   assign last_voice = (idx_q == LAST_IDX);

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         en_q         <= '0;
         idx_q        <= '0;
         have_acc_q   <= 1'b0;
         acc_q        <= '0;
         wcnt_q       <= '0;
         mix_a_q      <= SILENCE;
         mix_b_q      <= SILENCE;
         out_sample_q <= SILENCE;
         out_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         en_q         <= en_d;
         idx_q        <= idx_d;
         have_acc_q   <= have_acc_d;
         acc_q        <= acc_d;
         wcnt_q       <= wcnt_d;
         mix_a_q      <= mix_a_d;
         mix_b_q      <= mix_b_d;
         out_sample_q <= out_sample_d;
         out_valid_q  <= out_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   // Next-state logic: scan voices, issue mixer passes, wait, publish.
   always_comb begin
      state_d      = state_q;
      en_d         = en_q;
      idx_d        = idx_q;
      have_acc_d   = have_acc_q;
      acc_d        = acc_q;
      wcnt_d       = wcnt_q;
      mix_a_d      = mix_a_q;
      mix_b_d      = mix_b_q;
      out_sample_d = out_sample_q;
      out_valid_d  = 1'b0;
      // A tick outside IDLE (DONE included) is dropped but flagged.
      overrun_d    = sample_tick && (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (sample_tick) begin
               en_d       = voice_en;
               idx_d      = '0;
               have_acc_d = 1'b0;
               state_d    = ST_SCAN;
            end
         end

         ST_SCAN: begin
            if (en_q[idx_q] && have_acc_q) begin
               // Operands stay frozen until the result is captured.
               mix_a_d = acc_q;
               mix_b_d = voice_sample;
               wcnt_d  = WCNT_INI;
               state_d = ST_WAIT;
            end else begin
               if (en_q[idx_q]) begin
                  acc_d      = voice_sample;
                  have_acc_d = 1'b1;
               end
               if (last_voice) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         ST_WAIT: begin
            if (wcnt_q == '0) begin
               acc_d = mix_z;
               if (last_voice) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_SCAN;
               end
            end else begin
               wcnt_d = wcnt_q - 1'b1;
            end
         end

         ST_DONE: begin
            out_sample_d = have_acc_q ? acc_q : SILENCE;
            out_valid_d  = 1'b1;
            state_d      = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

`ifdef VOICE_MIX_SCHED_OVERRUN_CNT_EN
   logic [15:0] ovr_cnt_q, ovr_cnt_d;

   // Saturating count of overrun pulses; cleared only by reset.
   always_comb begin
      ovr_cnt_d = ovr_cnt_q;
      if (overrun_q && (ovr_cnt_q != 16'hFFFF)) begin
         ovr_cnt_d = ovr_cnt_q + 16'd1;
      end
   end

   // Overrun counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovr_cnt_q <= '0;
      end else begin
         ovr_cnt_q <= ovr_cnt_d;
      end
   end

   assign overrun_cnt = ovr_cnt_q;
`endif

   assign voice_sel  = idx_q;
   assign mix_a      = mix_a_q;
   assign mix_b      = mix_b_q;
   assign out_sample = out_sample_q;
   assign out_valid  = out_valid_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != ST_IDLE);

endmodule
